// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb.sv
// Round-robin arbiter: one-hot grant plus owner index, holds while the owner requests, rotates on release.
// Latency 1 cycle REQ->GNT; optional forced release under macro GF180MCU_FD_SC_MCU9T5V0__RRARB_TIMEOUT_EN.
module gf180mcu_fd_sc_mcu9t5v0__rrarb #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [N-1:0]   REQ,
    output logic [N-1:0]   GNT,
    output logic [IDW-1:0] GNT_ID,
    output logic           VALID
);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("N out of range");
    end
    if (IDW != $clog2(N)) begin : g_bad_idw
        $error("IDW must equal clog2(N)");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD out of range");
    end

    typedef enum logic {IDLE, OWN} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   cand;
    logic [IDW-1:0] base;
    logic [IDW-1:0] owner_next_ptr;
    logic [IDW-1:0] pick;
    logic           found;
    logic           release_own;
    logic           forced;
    int             scan_idx;

`ifdef GF180MCU_FD_SC_MCU9T5V0__RRARB_TIMEOUT_EN
    logic [7:0] hc_q, hc_d;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
`ifdef GF180MCU_FD_SC_MCU9T5V0__RRARB_TIMEOUT_EN
            hc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
`ifdef GF180MCU_FD_SC_MCU9T5V0__RRARB_TIMEOUT_EN
            hc_q    <= hc_d;
`endif
        end
    end

    // While owning, the search starts just past the owner and never re-picks it.
    assign owner_next_ptr = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
    assign cand = (state_q == OWN) ? (REQ & ~GNT) : REQ;
    assign base = (state_q == OWN) ? owner_next_ptr : ptr_q;

    // Scan offsets high to low so the smallest offset from base wins.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            scan_idx = int'(base) + i;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            if (cand[scan_idx]) begin
                found = 1'b1;
                pick  = IDW'(scan_idx);
            end
        end
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0__RRARB_TIMEOUT_EN
    assign forced = (hc_q == 8'(MAX_HOLD - 1)) && (|cand);
`else
    assign forced = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        release_own = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    owner_d = pick;
                end
            end
            OWN: begin
                release_own = !REQ[owner_q] || forced;
                if (release_own) begin
                    ptr_d = owner_next_ptr;
                    if (found) begin
                        owner_d = pick;
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0__RRARB_TIMEOUT_EN
    // Counter saturates one short of MAX_HOLD when nobody else is waiting.
    always_comb begin
        hc_d = hc_q;
        if (state_q == IDLE || release_own)
            hc_d = '0;
        else if (hc_q != 8'(MAX_HOLD - 1))
            hc_d = hc_q + 8'd1;
    end
`endif

    always_comb begin
        GNT    = '0;
        GNT_ID = '0;
        VALID  = (state_q == OWN);
        if (state_q == OWN) begin
            GNT_ID = owner_q;
            for (int i = 0; i < N; i++)
                GNT[i] = (owner_q == IDW'(i));
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rrarb.sv
// Self-checking bench for the round-robin arbiter: directed scenarios plus random traffic against a reference model.
module tb_gf180mcu_fd_sc_mcu9t5v0__rrarb;

    localparam int N = 4;
    localparam int IDW = 2;
    localparam int MAX_HOLD = 4;
`ifdef GF180MCU_FD_SC_MCU9T5V0__RRARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           valid;

    int checks = 0;
    int failures = 0;

    // Reference state: owner index (-1 when idle), priority pointer, hold count.
    int m_own = -1;
    int m_ptr = 0;
    int m_hc = 0;

    gf180mcu_fd_sc_mcu9t5v0__rrarb #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .GNT(gnt), .GNT_ID(gnt_id), .VALID(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_from(input logic [N-1:0] r, input int p);
        for (int off = 0; off < N; off++)
            if (r[(p + off) % N]) return (p + off) % N;
        return -1;
    endfunction

    function automatic logic [N+IDW:0] expected();
        logic [N-1:0] g;
        g = '0;
        if (m_own >= 0) g[m_own] = 1'b1;
        return {g, (m_own >= 0) ? IDW'(m_own) : IDW'(0), m_own >= 0};
    endfunction

    task automatic model_edge(input logic [N-1:0] r, input logic rs);
        logic [N-1:0] others;
        if (rs) begin
            m_own = -1; m_ptr = 0; m_hc = 0;
        end else if (m_own < 0) begin
            if (r != 0) begin
                m_own = first_from(r, m_ptr);
                m_hc = 0;
            end
        end else begin
            others = r;
            others[m_own] = 1'b0;
            if (!r[m_own] || (TIMEOUT && m_hc == MAX_HOLD - 1 && others != 0)) begin
                m_ptr = (m_own + 1) % N;
                m_own = (others != 0) ? first_from(others, m_ptr) : -1;
                m_hc = 0;
            end else if (m_hc < MAX_HOLD - 1) begin
                m_hc = m_hc + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(req, rst);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({gnt, gnt_id, valid} !== 7'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got gnt=%b id=%0d vld=%b want 0", i, gnt, gnt_id, valid);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({gnt, gnt_id, valid} !== {4'b0001, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_first_grant got gnt=%b id=%0d vld=%b want 0001/0/1", gnt, gnt_id, valid);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        req = 4'b1111;
        tick();
        for (int r = 0; r < 4; r++) begin
            tick(); tick();
            checks++;
            if (gnt !== 4'(1 << r)) begin
                failures++;
                $display("FAIL rotation_hold owner=%0d got gnt=%b want %b", r, gnt, 4'(1 << r));
            end
            req[r] = 1'b0;
            tick();
            req = 4'b1111;
            checks++;
            if ({gnt, gnt_id, valid} !== {4'(1 << ((r + 1) % 4)), 2'((r + 1) % 4), 1'b1}) begin
                failures++;
                $display("FAIL rotation_handover from=%0d got gnt=%b id=%0d vld=%b", r, gnt, gnt_id, valid);
            end
        end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] stim [6] = '{4'b0100, 4'b0000, 4'b0110, 4'b0100, 4'b0000, 4'b1001};
        logic [3:0] want [6] = '{4'b0100, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b1000};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req = stim[i];
            tick();
            checks++;
            if (gnt !== want[i] || valid !== (want[i] != 0)) begin
                failures++;
                $display("FAIL wrap_skip step=%0d got gnt=%b vld=%b want %b", i, gnt, valid, want[i]);
            end
        end
    endtask

    task automatic test_single();
        int bad = 0;
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({gnt, gnt_id, valid} !== {4'b1000, 2'd3, 1'b1}) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL single_hold got %0d bad cycles want 0", bad);
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({gnt, gnt_id, valid} !== 7'b0) begin
            failures++;
            $display("FAIL single_idle got gnt=%b id=%0d vld=%b want 0", gnt, gnt_id, valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010; tick();
        req = 4'b0100; tick();
        rst = 1'b1; tick();
        checks++;
        if ({gnt, gnt_id, valid} !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid_drop got gnt=%b vld=%b want 0", gnt, valid);
        end
        rst = 1'b0; req = 4'b1001; tick();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid_ptr got gnt=%b want 0001", gnt);
        end
        do_reset();
        req = 4'b0100; tick();
        checks++;
        if ({gnt, gnt_id, valid} !== {4'b0100, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_regrant got gnt=%b id=%0d want 0100/2", gnt, gnt_id);
        end
    endtask

    task automatic test_timeout();
        int want_own;
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 16; i++) begin
            tick();
            want_own = TIMEOUT ? (i / MAX_HOLD) % 2 : 0;
            checks++;
            if ({gnt, gnt_id} !== {4'(1 << want_own), 2'(want_own)}) begin
                failures++;
                $display("FAIL timeout cyc=%0d got gnt=%b id=%0d want owner %0d", i, gnt, gnt_id, want_own);
            end
        end
    endtask

    task automatic test_random();
        logic [N+IDW:0] exp_v;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3, 0) == 0) req = 4'($urandom_range(15, 0));
            rst = ($urandom_range(63, 0) == 0);
            tick();
            exp_v = expected();
            checks++;
            if ({gnt, gnt_id, valid} !== exp_v) begin
                failures++;
                $display("FAIL random cyc=%0d req=%b got gnt=%b id=%0d vld=%b want %b/%0d/%b",
                         i, req, gnt, gnt_id, valid, exp_v[6:3], exp_v[2:1], exp_v[0]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        test_reset();
        test_rotation();
        test_wrap_skip();
        test_single();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
